// File: rtl/viol_reset_if.sv
// rtl/viol_reset_if.sv - violation merge / reset request signal bundle
interface viol_reset_if #(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 8
);
  logic [15:0]        pc;
  logic [NUM_SRC-1:0] viol_in;
  logic               cause_clr;
  logic               sys_rst_req;
  logic [NUM_SRC-1:0] viol_cause;
  logic [CNT_W-1:0]   viol_cnt;
  logic               busy;

  modport master (
    output pc, viol_in, cause_clr,
    input  sys_rst_req, viol_cause, viol_cnt, busy
  );

  modport slave (
    input  pc, viol_in, cause_clr,
    output sys_rst_req, viol_cause, viol_cnt, busy
  );
endinterface

// File: rtl/viol_reset_ctrl.sv
// rtl/viol_reset_ctrl.sv - merges monitor violations into a stretched PUC reset request
module viol_reset_ctrl #(
  parameter int          NUM_SRC         = 3,
  parameter int          RST_CYCLES      = 4,
  parameter int          RECOVER_TIMEOUT = 64,
  parameter logic [15:0] RESET_HANDLER   = 16'h0000,
  parameter int          CNT_W           = 8
) (
  input  logic         mclk,
  input  logic         reset_n,
  viol_reset_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    ASSERT  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(RECOVER_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [15:0]        timer, timer_nxt;
  logic [NUM_SRC-1:0] cause_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_sat_inc;
  logic               any_viol;
  logic               at_handler;

  assign any_viol    = |bus.viol_in;
  assign at_handler  = (bus.pc == RESET_HANDLER);
  assign cnt_sat_inc = (bus.viol_cnt == {CNT_W{1'b1}}) ? bus.viol_cnt
                                                        : bus.viol_cnt + CNT_W'(1);

  // State, timer and all outputs are registered; outputs reflect the state being entered.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= BOOT;
      timer           <= 16'd0;
      bus.sys_rst_req <= 1'b0;
      bus.viol_cause  <= '0;
      bus.viol_cnt    <= '0;
      bus.busy        <= 1'b1;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      bus.sys_rst_req <= (state_nxt == ASSERT);
      bus.viol_cause  <= cause_nxt;
      bus.viol_cnt    <= cnt_nxt;
      bus.busy        <= (state_nxt != IDLE);
    end
  end

  // Next-state, timer, cause and counter; monitors are ignored until the CPU reaches the handler.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cause_nxt = bus.viol_cause;
    cnt_nxt   = bus.viol_cnt;
    case (state)
      BOOT: begin
        if (at_handler) state_nxt = IDLE;
      end
      IDLE: begin
        // A clear in the same cycle as a new violation leaves only the new cause.
        cause_nxt = (bus.cause_clr ? '0 : bus.viol_cause) | bus.viol_in;
        if (any_viol) begin
          state_nxt = ASSERT;
          timer_nxt = RST_LOAD;
          cnt_nxt   = cnt_sat_inc;
        end
      end
      ASSERT: begin
        cause_nxt = bus.viol_cause | bus.viol_in;
        if (timer == 16'd0) begin
          state_nxt = RECOVER;
          timer_nxt = 16'd0;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      RECOVER: begin
        cause_nxt = bus.viol_cause | bus.viol_in;
        // A clean re-entry into the handler wins over the timeout.
        if (at_handler && !any_viol) begin
          state_nxt = IDLE;
        end else if (timer == TO_LAST) begin
          state_nxt = ASSERT;
          timer_nxt = RST_LOAD;
          cnt_nxt   = cnt_sat_inc;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: begin
        state_nxt = BOOT;
        timer_nxt = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_viol_reset_ctrl.sv
// tb/tb_viol_reset_ctrl.sv - randomized model-checked bench for viol_reset_ctrl
module tb_viol_reset_ctrl;
  localparam int          NUM_SRC         = 3;
  localparam int          RST_CYCLES      = 4;
  localparam int          RECOVER_TIMEOUT = 64;
  localparam int          CNT_W           = 8;
  localparam logic [15:0] RH              = 16'h0000;
  localparam int          CNT_MAX         = (1 << CNT_W) - 1;

  logic mclk    = 1'b0;
  logic reset_n = 1'b0;
  always #5 mclk = ~mclk;

  viol_reset_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) vif ();

  viol_reset_ctrl #(
    .NUM_SRC(NUM_SRC), .RST_CYCLES(RST_CYCLES), .RECOVER_TIMEOUT(RECOVER_TIMEOUT),
    .RESET_HANDLER(RH), .CNT_W(CNT_W)
  ) dut (
    .mclk(mclk),
    .reset_n(reset_n),
    .bus(vif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: booted flag, remaining request cycles, age within the recovery window.
  bit           m_booted;
  int           m_pulse;
  int           m_age;
  logic [2:0]   m_cause;
  int           m_cnt;

  task automatic model_step(input logic [2:0] v, input logic [15:0] p, input logic c);
    if (!m_booted) begin
      if (p == RH) m_booted = 1'b1;
    end else if (m_pulse > 0) begin
      m_cause |= v;
      m_pulse--;
      if (m_pulse == 0) m_age = 0;
    end else if (m_age >= 0) begin
      m_cause |= v;
      if (p == RH && v == 3'b000) begin
        m_age = -1;
      end else if (m_age == RECOVER_TIMEOUT - 1) begin
        m_age   = -1;
        m_pulse = RST_CYCLES;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_age++;
      end
    end else begin
      if (c) m_cause = 3'b000;
      if (v != 3'b000) begin
        m_cause |= v;
        m_pulse = RST_CYCLES;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  // Advance the model on every edge (or reset) and compare all outputs 1 ns later.
  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      m_booted = 1'b0; m_pulse = 0; m_age = -1; m_cause = 3'b000; m_cnt = 0;
    end else begin
      model_step(vif.viol_in, vif.pc, vif.cause_clr);
    end
    #1;
    check("cmp_req",   vif.sys_rst_req, (m_pulse > 0));
    check("cmp_busy",  vif.busy, (!m_booted || m_pulse > 0 || m_age >= 0));
    check("cmp_cause", vif.viol_cause, m_cause);
    check("cmp_cnt",   vif.viol_cnt, m_cnt);
  end

  task automatic drive(input logic [2:0] v, input logic [15:0] p, input logic c);
    @(negedge mclk);
    vif.viol_in   = v;
    vif.pc        = p;
    vif.cause_clr = c;
  endtask

  // Fire one violation cycle, return the measured request width; leaves us at the first low negedge.
  task automatic violate(input logic [2:0] v, input logic [15:0] p, output int width);
    int guard;
    drive(v, p, 1'b0);
    @(negedge mclk);
    vif.viol_in = 3'b000;
    width = 0;
    guard = 0;
    while (vif.sys_rst_req === 1'b1 && guard < 40) begin
      width++;
      guard++;
      @(negedge mclk);
    end
    if (guard >= 40) check("pulse_bound", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (vif.busy !== 1'b0 && n < budget) begin
      @(negedge mclk);
      n++;
    end
    check("idle_reached", (n < budget), 1'b1);
  endtask

  initial begin
    int w, lows, cnt_before, guard;
    vif.viol_in   = 3'b001;
    vif.pc        = 16'h0000;
    vif.cause_clr = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_req", vif.sys_rst_req, 1'b0);
    check("rst_cnt", vif.viol_cnt, 8'h00);

    // 1: BOOT ignores the pending violation, IDLE picks it up one edge later.
    #2 reset_n = 1'b1;
    @(negedge mclk);
    check("t1_boot_no_req", vif.sys_rst_req, 1'b0);
    check("t1_in_idle", vif.busy, 1'b0);
    @(negedge mclk);
    vif.viol_in = 3'b000;
    w = 0;
    guard = 0;
    while (vif.sys_rst_req === 1'b1 && guard < 40) begin
      w++; guard++; @(negedge mclk);
    end
    check("t1_width", w, 4);
    check("t1_cause", vif.viol_cause, 3'b001);
    check("t1_cnt", vif.viol_cnt, 8'd1);
    wait_idle(20);

    // 2: single-cycle violation, clean return to handler.
    violate(3'b010, 16'h0000, w);
    check("t2_width", w, 4);
    @(negedge mclk);
    check("t2_busy", vif.busy, 1'b0);
    check("t2_cause", vif.viol_cause, 3'b011);

    // 3: recovery timeout re-asserts after 64 cycles away from the handler.
    cnt_before = vif.viol_cnt;
    violate(3'b001, 16'hE000, w);
    lows = 0;
    while (vif.sys_rst_req === 1'b0 && lows < 200) begin
      lows++; @(negedge mclk);
    end
    check("t3_recover_len", lows, 64);
    check("t3_cnt", vif.viol_cnt, cnt_before + 2);
    guard = 0;
    while (vif.sys_rst_req === 1'b1 && guard < 40) begin
      guard++; @(negedge mclk);
    end
    // handler reached in the very last recovery cycle: exit wins over timeout
    repeat (63) begin vif.pc = 16'hE000; @(negedge mclk); end
    vif.pc = 16'h0000;
    @(negedge mclk);
    check("t3_exit_busy", vif.busy, 1'b0);
    check("t3_exit_cnt", vif.viol_cnt, cnt_before + 2);
    repeat (3) @(negedge mclk);
    check("t3_no_reassert", vif.sys_rst_req, 1'b0);

    // 4: new cause mid-pulse keeps width; clear is ignored in recovery.
    drive(3'b000, 16'h0000, 1'b1);
    drive(3'b001, 16'h0000, 1'b0);
    @(negedge mclk);
    vif.viol_in = 3'b100;
    w = 0;
    guard = 0;
    while (vif.sys_rst_req === 1'b1 && guard < 40) begin
      w++; guard++; @(negedge mclk); vif.viol_in = 3'b000;
    end
    check("t4_width", w, 4);
    check("t4_cause", vif.viol_cause, 3'b101);
    vif.pc = 16'hE000; vif.cause_clr = 1'b1;
    @(negedge mclk);
    check("t4_clr_ignored", vif.viol_cause, 3'b101);
    vif.pc = 16'h0000; vif.cause_clr = 1'b0;
    wait_idle(20);

    // 5: clear and violation together in IDLE.
    cnt_before = vif.viol_cnt;
    drive(3'b001, 16'h0000, 1'b1);
    @(negedge mclk);
    vif.viol_in = 3'b000; vif.cause_clr = 1'b0;
    check("t5_cause", vif.viol_cause, 3'b001);
    check("t5_req", vif.sys_rst_req, 1'b1);
    check("t5_cnt", vif.viol_cnt, cnt_before + 1);
    wait_idle(20);

    // 6: saturation, then asynchronous reset mid-pulse.
    for (int i = 0; i < 300; i++) begin
      violate(3'b010, 16'h0000, w);
      wait_idle(20);
    end
    check("t6_sat", vif.viol_cnt, 8'hFF);
    drive(3'b001, 16'h0000, 1'b0);
    @(negedge mclk);
    vif.viol_in = 3'b000;
    check("t6_in_assert", vif.sys_rst_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_req", vif.sys_rst_req, 1'b0);
    check("t6_async_cnt", vif.viol_cnt, 8'h00);
    check("t6_async_cause", vif.viol_cause, 3'b000);
    @(negedge mclk);
    #2 reset_n = 1'b1;

    // Randomized traffic, including reset pulses away from the clock edge.
    for (int i = 0; i < 4000; i++) begin
      logic [2:0]  v;
      logic [15:0] p;
      v = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      p = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      drive(v, p, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge mclk);
        #2 reset_n = 1'b1;
      end
    end

    repeat (2) @(negedge mclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
